// File: rtl/clock_pkg.sv
// Shared types and elaboration-time helpers for the PLL lock qualifier / reset sequencer.
package clock_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  function automatic logic params_legal(input int unsigned channels,
                                        input int unsigned sync_stages,
                                        input int unsigned hold_cycles,
                                        input int unsigned rst_hold,
                                        input int unsigned cnt_w);
    return (channels >= 1) && (sync_stages >= 2) && (hold_cycles >= 1) &&
           (rst_hold >= 1) && (cnt_w >= 1);
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_qualifier.sv
// One channel: synchroniser chain, stability hold-off counter and qualified locked flag.
module lock_qualifier
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_in,
  output logic locked,
  output logic loss_pulse
);

  localparam int unsigned HW = cnt_width(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   locked_q, locked_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], lock_in};
    hold_d   = hold_q;
    locked_d = locked_q;
    if (!sync_out) begin
      hold_d   = '0;
      locked_d = 1'b0;
    end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
      locked_d = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      hold_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hold_q   <= hold_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
  // Marks the edge on which locked falls; falls forced by rst are excluded.
  assign loss_pulse = locked_q & ~sync_out & ~rst;

endmodule

// File: rtl/clock_lock_seq.sv
// Multi-PLL lock qualifier with loss accounting and a sequenced downstream reset.
module clock_lock_seq
  import clock_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RST_HOLD    = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] lock_in,
  input  logic                loss_clear,
  output logic [CHANNELS-1:0] locked,
  output logic                all_locked,
  output logic                rst_out,
  output logic [CHANNELS-1:0] loss_sticky,
  output logic [CNT_W-1:0]    loss_count,
  output logic [1:0]          seq_state
);

  localparam int unsigned PW = cnt_width(CHANNELS);
  localparam int unsigned SW = CNT_W + PW;
  localparam int unsigned RW = cnt_width(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!params_legal(CHANNELS, SYNC_STAGES, HOLD_CYCLES, RST_HOLD, CNT_W)) begin : g_bad_params
    $error("clock_lock_seq: illegal parameter set");
  end

  logic [CHANNELS-1:0] loss_pulse;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    lock_qualifier #(
      .SYNC_STAGES(SYNC_STAGES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_lq (
      .clk       (clk),
      .rst       (rst),
      .lock_in   (lock_in[i]),
      .locked    (locked[i]),
      .loss_pulse(loss_pulse[i])
    );
  end

  assign all_locked = &locked;

  // Loss accounting
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PW-1:0]       loss_pop;
  logic [SW-1:0]       loss_sum;

  always_comb begin
    loss_pop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      loss_pop = loss_pop + PW'(loss_pulse[i]);
    end
    // A simultaneous clear zeroes the base, so new events still land.
    loss_sum = loss_clear ? SW'(loss_pop) : (SW'(count_q) + SW'(loss_pop));
    count_d  = (loss_sum > SW'(CNT_MAX)) ? CNT_MAX : loss_sum[CNT_W-1:0];
    sticky_d = (loss_clear ? '0 : sticky_q) | loss_pulse;
  end

  // Sequencer
  seq_state_t      seq_q, seq_d;
  logic [RW-1:0]   seq_cnt_q, seq_cnt_d;
  logic            rst_out_q, rst_out_d;

  always_comb begin
    seq_d     = seq_q;
    seq_cnt_d = seq_cnt_q;
    rst_out_d = rst_out_q;
    case (seq_q)
      WAIT: begin
        rst_out_d = 1'b1;
        if (all_locked) begin
          seq_d     = HOLD;
          seq_cnt_d = '0;
        end
      end
      HOLD: begin
        rst_out_d = 1'b1;
        if (!all_locked) begin
          seq_d = WAIT;
        end else if (seq_cnt_q == RW'(RST_HOLD - 1)) begin
          seq_d     = RUN;
          rst_out_d = 1'b0;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_out_d = 1'b0;
        if (!all_locked) begin
          seq_d     = WAIT;
          rst_out_d = 1'b1;
        end
      end
      default: begin
        seq_d     = WAIT;
        rst_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q  <= '0;
      count_q   <= '0;
      seq_q     <= WAIT;
      seq_cnt_q <= '0;
      rst_out_q <= 1'b1;
    end else begin
      sticky_q  <= sticky_d;
      count_q   <= count_d;
      seq_q     <= seq_d;
      seq_cnt_q <= seq_cnt_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign loss_sticky = sticky_q;
  assign loss_count  = count_q;
  assign rst_out     = rst_out_q;
  assign seq_state   = seq_q;

endmodule

// File: tb/tb_clock_lock_seq.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a reference model.
module tb_clock_lock_seq;

  localparam int CH   = 2;
  localparam int S    = 2;
  localparam int H    = 16;
  localparam int RH   = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] lock_in;
  logic          loss_clear;
  logic [CH-1:0] locked;
  logic          all_locked;
  logic          rst_out;
  logic [CH-1:0] loss_sticky;
  logic [CW-1:0] loss_count;
  logic [1:0]    seq_state;

  always #5 clk = ~clk;

  clock_lock_seq #(
    .CHANNELS(CH),
    .SYNC_STAGES(S),
    .HOLD_CYCLES(H),
    .RST_HOLD(RH),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_in    (lock_in),
    .loss_clear (loss_clear),
    .locked     (locked),
    .all_locked (all_locked),
    .rst_out    (rst_out),
    .loss_sticky(loss_sticky),
    .loss_count (loss_count),
    .seq_state  (seq_state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: delayed sample history, run lengths, consecutive all-locked count.
  logic [CH-1:0] samp_q[$];
  int            run_len[CH];
  logic [CH-1:0] m_locked;
  logic [CH-1:0] m_sticky;
  int            m_count;
  int            m_all_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] delayed;
    logic [CH-1:0] nl;
    logic [CH-1:0] loss;
    if (rst) begin
      samp_q.delete();
      for (int i = 0; i < CH; i++) run_len[i] = 0;
      m_locked  = '0;
      m_sticky  = '0;
      m_count   = 0;
      m_all_run = 0;
    end else begin
      m_all_run = (&m_locked) ? ((m_all_run < 1000) ? m_all_run + 1 : m_all_run) : 0;
      samp_q.push_back(lock_in);
      delayed = '0;
      if (samp_q.size() > S) delayed = samp_q.pop_front();
      nl = '0;
      for (int i = 0; i < CH; i++) begin
        run_len[i] = delayed[i] ? ((run_len[i] < 1000) ? run_len[i] + 1 : run_len[i]) : 0;
        nl[i] = (run_len[i] >= H);
      end
      loss = m_locked & ~nl;
      if (loss_clear) begin
        m_sticky = '0;
        m_count  = 0;
      end
      m_sticky = m_sticky | loss;
      m_count  = m_count + $countones(loss);
      if (m_count > CMAX) m_count = CMAX;
      m_locked = nl;
    end
  endtask

  function automatic logic [1:0] m_state();
    if (m_all_run == 0) return 2'd0;
    if (m_all_run <= RH) return 2'd1;
    return 2'd2;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_locked",     32'(locked),      32'(m_locked));
    check("model_all_locked", 32'(all_locked),  32'(&m_locked));
    check("model_rst_out",    32'(rst_out),     32'(m_all_run < RH + 1));
    check("model_sticky",     32'(loss_sticky), 32'(m_sticky));
    check("model_count",      32'(loss_count),  32'(m_count));
    check("model_state",      32'(seq_state),   32'(m_state()));
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  typedef struct {
    logic          r;
    logic [CH-1:0] lk;
    logic          clr;
    int            n;
    logic [CH-1:0] e_locked;
    logic          e_rst_out;
    logic [1:0]    e_state;
    logic [CH-1:0] e_sticky;
    int            e_count;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst        = 1'b1;
    lock_in    = '0;
    loss_clear = 1'b0;

    // Bring-up, RUN, single-channel loss and relock, dual loss with clear.
    tbl.push_back('{1'b1, 2'b00, 1'b0,  2, 2'b00, 1'b1, 2'd0, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 17, 2'b00, 1'b1, 2'd0, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  1, 2'b11, 1'b1, 2'd0, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  1, 2'b11, 1'b1, 2'd1, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  7, 2'b11, 1'b1, 2'd1, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  1, 2'b11, 1'b0, 2'd2, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  5, 2'b11, 1'b0, 2'd2, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0,  2, 2'b11, 1'b0, 2'd2, 2'b00, 0});
    tbl.push_back('{1'b0, 2'b01, 1'b0,  1, 2'b01, 1'b0, 2'd2, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b01, 1'b0,  1, 2'b01, 1'b1, 2'd0, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 17, 2'b01, 1'b1, 2'd0, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  1, 2'b11, 1'b1, 2'd0, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0,  9, 2'b11, 1'b0, 2'd2, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b00, 1'b0,  2, 2'b11, 1'b0, 2'd2, 2'b10, 1});
    tbl.push_back('{1'b0, 2'b00, 1'b1,  1, 2'b00, 1'b0, 2'd2, 2'b11, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0,  1, 2'b00, 1'b1, 2'd0, 2'b11, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1,  1, 2'b00, 1'b1, 2'd0, 2'b00, 0});

    for (int v = 0; v < tbl.size(); v++) begin
      rst        = tbl[v].r;
      lock_in    = tbl[v].lk;
      loss_clear = tbl[v].clr;
      run_n(tbl[v].n);
      check($sformatf("vec%0d_locked", v),  32'(locked),      32'(tbl[v].e_locked));
      check($sformatf("vec%0d_rst_out", v), 32'(rst_out),     32'(tbl[v].e_rst_out));
      check($sformatf("vec%0d_state", v),   32'(seq_state),   32'(tbl[v].e_state));
      check($sformatf("vec%0d_sticky", v),  32'(loss_sticky), 32'(tbl[v].e_sticky));
      check($sformatf("vec%0d_count", v),   32'(loss_count),  32'(tbl[v].e_count));
    end
    loss_clear = 1'b0;

    // One-cycle glitch on channel 0 inside its hold window restarts the count.
    rst = 1'b1; lock_in = '0;
    step();
    rst = 1'b0; lock_in = 2'b11;
    run_n(11);
    lock_in = 2'b10;
    step();
    lock_in = 2'b11;
    run_n(17);
    check("glitch_locked_partial", 32'(locked), 32'(2'b10));
    step();
    check("glitch_locked_full", 32'(locked), 32'(2'b11));
    check("glitch_no_loss", 32'(loss_count), 32'd0);
    check("glitch_no_sticky", 32'(loss_sticky), 32'(2'b00));

    // rst during HOLD returns everything to reset values on the next edge.
    step();
    check("hold_entered", 32'(seq_state), 32'd1);
    rst = 1'b1;
    step();
    check("rst_hold_locked", 32'(locked), 32'(2'b00));
    check("rst_hold_rst_out", 32'(rst_out), 32'd1);
    check("rst_hold_state", 32'(seq_state), 32'd0);
    check("rst_hold_all_locked", 32'(all_locked), 32'd0);
    rst = 1'b0;

    // 300 single-channel loss events saturate the counter.
    for (int k = 0; k < 300; k++) begin
      lock_in = 2'b11;
      run_n(20);
      lock_in = 2'b10;
      run_n(4);
    end
    check("sat_count", 32'(loss_count), 32'(CMAX));
    check("sat_sticky", 32'(loss_sticky), 32'(2'b01));
    loss_clear = 1'b1;
    step();
    loss_clear = 1'b0;
    check("sat_cleared", 32'(loss_count), 32'd0);

    // Random traffic against the model.
    lock_in = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 39) == 0) lock_in[i] = ~lock_in[i];
      end
      loss_clear = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    loss_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
